// File: rtl/my_ram8.sv
// Eight-word register file: one write port, one combinational read port.
// Also tracks which words hold written data and counts accepted writes.
module my_ram8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       address,
    input  logic             load,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       valid,
    output logic [7:0]       wr_count
);

    logic [WIDTH-1:0] mem_q [8];
    logic [7:0]       valid_q;
    logic [7:0]       count_q;
    logic [7:0]       load_dec;

    // One-hot write strobe: the demux stage steering load to a single word.
    always_comb begin
        load_dec = '0;
        for (int i = 0; i < 8; i++) begin
            load_dec[i] = load && (address == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else if (clr) begin
            // Clear wins over a simultaneous load; that write is dropped.
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load_dec[i]) begin
                    mem_q[i]   <= in;
                    valid_q[i] <= 1'b1;
                end
            end
            if (load && count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign out      = mem_q[address];
    assign valid    = valid_q;
    assign wr_count = count_q;

endmodule

// File: tb/tb_my_ram8.sv
// Directed bench for my_ram8: reset, walk write/read, read-during-write,
// clear priority, count saturation and asynchronous reset.
module tb_my_ram8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic [2:0]  address;
    logic        load;
    logic        clr;
    logic [15:0] out;
    logic [7:0]  valid;
    logic [7:0]  wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    my_ram8 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .address  (address),
        .load     (load),
        .clr      (clr),
        .out      (out),
        .valid    (valid),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in      = d;
        load    = 1'b1;
        clr     = 1'b0;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        address = a;
        #1;
        check($sformatf("%s[%0d]", tag, a), 32'(out), 32'(exp));
    endtask

    initial begin
        logic [15:0] exp_mem [8];

        // Reset held with an active write strobe must store nothing.
        rst_n   = 1'b0;
        in      = 16'hFFFF;
        load    = 1'b1;
        clr     = 1'b0;
        address = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "reset_out");
        check("reset_valid", 32'(valid), 32'h00);
        check("reset_count", 32'(wr_count), 32'd0);

        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;

        // Walk write/read.
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'h1000 + 16'(i));
            exp_mem[i] = 16'h1000 + 16'(i);
        end
        for (int i = 0; i < 8; i++) rd(3'(i), exp_mem[i], "walk");
        check("walk_valid", 32'(valid), 32'hFF);
        check("walk_count", 32'(wr_count), 32'd8);

        wr(3'd3, 16'hBEEF);
        exp_mem[3] = 16'hBEEF;
        for (int i = 0; i < 8; i++) rd(3'(i), exp_mem[i], "rewrite");
        check("rewrite_count", 32'(wr_count), 32'd9);

        // Read-during-write at address 5: old value before edge, new after.
        wr(3'd5, 16'h0005);
        exp_mem[5] = 16'h0005;
        @(negedge clk);
        address = 3'd5;
        in      = 16'hAAAA;
        load    = 1'b1;
        #1;
        check("rdw_before", 32'(out), 32'h0005);
        @(posedge clk);
        #1;
        load = 1'b0;
        check("rdw_after", 32'(out), 32'hAAAA);
        exp_mem[5] = 16'hAAAA;
        for (int i = 0; i < 8; i++) rd(3'(i), exp_mem[i], "rdw_others");
        check("rdw_count", 32'(wr_count), 32'd11);

        // Clear has priority over a simultaneous load.
        @(negedge clk);
        address = 3'd2;
        in      = 16'h1234;
        load    = 1'b1;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        clr  = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "clr_out");
        check("clr_valid", 32'(valid), 32'h00);
        check("clr_count", 32'(wr_count), 32'd0);

        // Saturation: 260 writes to address 7.
        for (int i = 0; i < 260; i++) begin
            wr(3'd7, 16'(i));
            if (i == 253) check("sat_254", 32'(wr_count), 32'd254);
            if (i == 254) check("sat_255", 32'(wr_count), 32'd255);
        end
        check("sat_count", 32'(wr_count), 32'd255);
        check("sat_valid", 32'(valid), 32'h80);
        rd(3'd7, 16'h0103, "sat_word");

        // Asynchronous reset between edges.
        wr(3'd0, 16'h5A5A);
        wr(3'd4, 16'hC3C3);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        address = 3'd4;
        #1;
        check("async_out", 32'(out), 32'h0000);
        check("async_valid", 32'(valid), 32'h00);
        check("async_count", 32'(wr_count), 32'd0);
        address = 3'd0;
        #1;
        check("async_out0", 32'(out), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/my_ram8.md
# my_ram8

Eight-word register file with one write port and one asynchronous read port, built on an internal 8-way demultiplexed load strobe. It sits directly downstream of the one-bit demultiplexer stage: the write-enable is steered to exactly one word register by address, so the demux fan-out drives clocked storage. The block also tracks which words hold written data and counts accepted writes, so the next layer (RAM64, CPU data memory) can check occupancy.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (legal 1..32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- out  output  WIDTH  word currently stored at address (combinational read)
- valid  output  8  bit i = 1 when word i has been written since last reset/clear
- wr_count  output  8  number of accepted writes since last reset/clear, saturating
- in  input  WIDTH  write data
- address  input  3  word select for both read and write
- load  input  1  write strobe, sampled on rising clk
- clr  input  1  synchronous clear-all, sampled on rising clk

## Operation
- Internal load decode: load_i = load & (address == i), i = 0..7; exactly one or zero strobes active per cycle.
- Reset (rst_n = 0, any time, independent of clk): all 8 words = 0, valid = 8'h00, wr_count = 0; out therefore reads 0 during reset. Held until rst_n returns high; first capture on the next rising clk after release.
- Write: on rising clk with load = 1, clr = 0: word[address] <= in; valid[address] <= 1; wr_count <= wr_count + 1 unless already 255 (stays 255).
- Overwrite of an already-valid word still counts as a write.
- Clear: on rising clk with clr = 1: all words = 0, valid = 0, wr_count = 0. clr has priority over load; a simultaneous load is discarded and not counted.
- Read: out = word[address] combinationally; no enable, address change reflected same cycle.
- Inputs in/address/load/clr are don't-care when rst_n = 0.
- X on load or address during a clock edge is illegal; behaviour undefined, bench must not drive it.

## Timing
- Write latency: stored value visible on out immediately after the rising edge that accepts it (0 cycles after edge, 1 cycle from strobe assertion).
- Read-during-write, same address: out shows the old value before the edge, the new value after it; no bypass.
- Read latency: combinational, no clock required.
- valid and wr_count update on the same edge as the word write.
- Reset assertion mid-cycle clears state immediately, without waiting for clk; a write on the same edge as reset release is not guaranteed and must not be relied on.
- wr_count saturation: 255 + write -> 255.

## Test plan
- Reset: drive rst_n = 0 with in = 16'hFFFF, load = 1, toggle clk 3x -> out = 0 for all 8 addresses, valid = 8'h00, wr_count = 0.
- Walk write/read: write 16'h1000 + i to address i for i = 0..7 -> each read returns 16'h1000 + i, valid = 8'hFF, wr_count = 8; rewriting address 3 with 16'hBEEF changes only word 3, wr_count = 9.
- Read-during-write: address = 5 holds 16'h0005, in = 16'hAAAA, load = 1 -> out = 16'h0005 before edge, 16'hAAAA after; other words unchanged.
- Clear priority: clr = 1 and load = 1 at address 2 with in = 16'h1234 on same edge -> all words 0, valid = 0, wr_count = 0, word 2 = 0.
- Saturation: 260 consecutive writes to address 7 -> wr_count = 255, word 7 = last written value, valid = 8'h80.
- Async reset mid-operation: after filling words, drop rst_n low between clock edges -> out, valid and wr_count go to 0 before the next rising clk.
